// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Holds FSM encodings, status bit positions and the status word builder.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int ST_EMPTY    = 4;
    localparam int ST_FULL     = 5;
    localparam int ST_BUSY     = 6;
    localparam int ST_OVF      = 7;
    localparam int CLR_OVF_BIT = 31;
    localparam int BAUD_W      = 16;

    function automatic logic [31:0] status_word(
        input logic [3:0] cnt,
        input logic       empty,
        input logic       full,
        input logic       busy,
        input logic       ovf
    );
        logic [31:0] w;
        w           = '0;
        w[3:0]      = cnt;
        w[ST_EMPTY] = empty;
        w[ST_FULL]  = full;
        w[ST_BUSY]  = busy;
        w[ST_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Pointer-based synchronous FIFO with occupancy count.
// Push when full and pop when empty are silently ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// Stores enqueue bytes; loads return a status word for polling.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    state_e            state_q;
    state_e            state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_q;
    logic              tx_d;
    logic              ovf_q;
    logic              ovf_d;

    logic [CW-1:0]     fifo_cnt;
    logic [7:0]        fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              is_clr;
    logic              push;
    logic              pop;
    logic              baud_last;
    logic              unused_wdata;

    assign is_clr       = writedata[CLR_OVF_BIT];
    assign push         = we && !is_clr;
    assign baud_last    = (baud_q == BAUD_MAX);
    assign unused_wdata = ^writedata[30:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (writedata[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = START;
            end
            START: begin
                if (baud_last) state_d = DATA;
            end
            DATA: begin
                if (baud_last && bit_q == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (baud_last) state_d = fifo_empty ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx_d follows the state being entered so the line is registered.
    always_comb begin
        pop  = 1'b0;
        tx_d = 1'b1;
        unique case (state_q)
            IDLE:    pop = !fifo_empty;
            STOP:    pop = baud_last && !fifo_empty;
            default: pop = 1'b0;
        endcase
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ovf_d   = ovf_q;
        if (pop) begin
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo_data;
        end else if (state_q == IDLE || baud_last) begin
            baud_d = '0;
            if (state_q == DATA) begin
                bit_d   = bit_q + 1'b1;
                shift_d = {1'b0, shift_q[7:1]};
            end
        end else begin
            baud_d = baud_q + 1'b1;
        end
        if (we) begin
            if (is_clr) begin
                ovf_d = 1'b0;
            end else if (fifo_full) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign readdata = status_word(4'(fifo_cnt), fifo_empty, fifo_full,
                                  state_q != IDLE, ovf_q);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected bytes,
// a line monitor decodes 8N1 frames from tx and compares them.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        tx;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb_q [$];

    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = '0;
    bit         rx_bad = 1'b0;
    logic [7:0] rx_exp;

    int bad;
    int n;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (we),
        .writedata (writedata),
        .readdata  (readdata),
        .tx        (tx)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; returns at the next negedge with we low.
    task automatic wr(input logic [31:0] d, input bit send);
        we = 1'b1;
        writedata = d;
        if (send) sb_q.push_back(d[7:0]);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (readdata !== 32'h10 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, readdata, 32'h10);
    endtask

    task automatic tx_quiet(input int cyc, input string name);
        int b;
        b = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (tx !== 1'b1) b++;
        end
        chk(name, b, 0);
    endtask

    // Line monitor: samples each bit at its centre, pops the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    rx_bad = 1'b0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act && (rx_cnt % CPB) == CPB / 2) begin
                if (rx_cnt / CPB == 0) begin
                    if (tx !== 1'b0) rx_bad = 1'b1;
                end else if (rx_cnt / CPB < 9) begin
                    rx_sh[rx_cnt / CPB - 1] = tx;
                end else begin
                    if (tx !== 1'b1) rx_bad = 1'b1;
                    rx_act = 1'b0;
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL frame: got %h, none expected", rx_sh);
                    end else begin
                        rx_exp = sb_q.pop_front();
                        if (rx_bad || rx_sh !== rx_exp) begin
                            failures++;
                            $display("FAIL frame: got %h framing_err=%0d expected %h",
                                     rx_sh, rx_bad, rx_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset and idle
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_status", readdata, 32'h10);
        chk("reset_tx", tx, 1);
        tx_quiet(100, "idle_tx_low_cycles");
        chk("idle_status", readdata, 32'h10);

        // 2: single frame 0x55
        wr(32'h55, 1'b1);
        chk("t2_count1", readdata, 32'h01);
        chk("t2_tx_before_pop", tx, 1);
        @(negedge clk);
        chk("t2_start_status", readdata, 32'h50);
        chk("t2_tx_start", tx, 0);
        bad = 0;
        repeat (39) begin
            @(negedge clk);
            if (readdata[6] !== 1'b1) bad++;
        end
        chk("t2_busy_gap_cycles", bad, 0);
        @(negedge clk);
        chk("t2_end_status", readdata, 32'h10);
        chk("t2_end_tx", tx, 1);
        chk("t2_sb_drained", sb_q.size(), 0);

        // 3: fill, overflow, clear, back-to-back frames
        wr(32'hA1, 1'b1);
        wr(32'hA2, 1'b1);
        wr(32'hA3, 1'b1);
        wr(32'hA4, 1'b1);
        wr(32'hA5, 1'b1);
        chk("t3_full", readdata, 32'h64);
        wr(32'hA6, 1'b0);
        chk("t3_ovf", readdata, 32'hE4);
        wr(32'h8000_0000, 1'b0);
        chk("t3_ovf_clear", readdata, 32'h64);
        n = 0;
        @(negedge clk);
        while (readdata[6] === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("t3_busy_run", n, 194);
        chk("t3_end_status", readdata, 32'h10);
        chk("t3_sb_drained", sb_q.size(), 0);

        // 4: push and pop on the same edge while full
        wr(32'h00, 1'b1);
        wr(32'hFF, 1'b1);
        wr(32'h81, 1'b1);
        wr(32'h7E, 1'b1);
        wr(32'hC3, 1'b1);
        repeat (36) @(negedge clk);
        chk("t4_pre_full", readdata, 32'h64);
        wr(32'h99, 1'b0);
        chk("t4_same_edge", readdata, 32'hC3);
        chk("t4_next_start", tx, 0);
        wr(32'h8000_0000, 1'b0);
        chk("t4_ovf_clear", readdata, 32'h43);
        wait_idle(220, "t4_end_status");
        chk("t4_sb_drained", sb_q.size(), 0);

        // 5: reset during data bit 3 with two bytes queued
        wr(32'hF7, 1'b0);
        wr(32'h12, 1'b0);
        wr(32'h34, 1'b0);
        chk("t5_queued", readdata, 32'h42);
        repeat (15) @(negedge clk);
        chk("t5_bit3_low", tx, 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5_reset_tx", tx, 1);
        chk("t5_reset_status", readdata, 32'h10);
        reset_n = 1'b1;
        tx_quiet(100, "t5_no_frames");
        chk("t5_idle_status", readdata, 32'h10);

        // 6: upper bits ignored; bit 31 clears instead of sending
        wr(32'h7FFF_FF3C, 1'b1);
        chk("t6_count1", readdata, 32'h01);
        wait_idle(60, "t6_end_status");
        wr(32'hFFFF_FF3C, 1'b0);
        chk("t6_clear_no_push", readdata, 32'h10);
        tx_quiet(50, "t6_no_frame");

        repeat (10) @(negedge clk);
        chk("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
